// File: rtl/audio_pkg.sv
// audio_pkg: shared fixed-point sample format for the audio processing chain
package audio_pkg;
  localparam int FXP_SIZE = 16;
  localparam int FXP_FRAC = 12;
  typedef logic signed [FXP_SIZE-1:0] sample_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: BCLK divider and frame bit counter with fall/load strobes
module i2s_clk_gen #(
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV = 4,
  localparam int BW = $clog2(2 * SLOT_BITS),
  localparam int DW = $clog2(BCLK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          o_bclk,
  output logic [BW-1:0] o_bit_nxt,
  output logic          o_bclk_fall,
  output logic          o_frame_load
);
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q;
  logic bclk_q, bclk_d, wrap;
  // strobes describe what the coming clk edge does; o_bit_nxt is the bit count after it
  always_comb begin
    wrap = div_q == DW'(BCLK_DIV - 1);
    o_bclk_fall = wrap & bclk_q;
    o_frame_load = o_bclk_fall & (bit_q == BW'(2 * SLOT_BITS - 1));
    div_d = wrap ? '0 : div_q + 1'b1;
    bclk_d = bclk_q ^ wrap;
    o_bit_nxt = o_frame_load ? '0 : o_bclk_fall ? bit_q + 1'b1 : bit_q;
  end
  // divider, bit clock and bit counter state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      bclk_q <= 1'b0;
      bit_q <= '0;
    end else begin
      div_q <= div_d;
      bclk_q <= bclk_d;
      bit_q <= o_bit_nxt;
    end
  end
  assign o_bclk = bclk_q;
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: mono sample holding register and I2S frame serializer
module i2s_tx #(
  parameter int FXP_SIZE = 16,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [FXP_SIZE-1:0] i_sample,
  output logic                o_frame_start,
  output logic                o_underrun,
  output logic                o_bclk,
  output logic                o_lrclk,
  output logic                o_sdata
);
  import audio_pkg::*;
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam int IW = $clog2(FXP_SIZE);
  logic bclk_fall, frame_load;
  logic [BW-1:0] bit_nxt;
  logic [FXP_SIZE-1:0] hold_q, hold_d, frame_q, frame_d;
  logic fresh_q, fresh_d, fs_q, ur_q, lr_q, lr_d, sd_q, sd_d;
  logic [IW-1:0] idx;
  int p;
  i2s_clk_gen #(
    .SLOT_BITS(SLOT_BITS),
    .BCLK_DIV(BCLK_DIV)
  ) u_clk_gen (
    .clk(clk),
    .rst(rst),
    .o_bclk(o_bclk),
    .o_bit_nxt(bit_nxt),
    .o_bclk_fall(bclk_fall),
    .o_frame_load(frame_load)
  );
  // a load takes the old hold value; a coincident sample waits for the next frame
  always_comb begin
    hold_d = i_valid ? i_sample : hold_q;
    fresh_d = i_valid | (fresh_q & ~frame_load);
    frame_d = frame_load ? hold_q : frame_q;
    p = int'(bit_nxt) % SLOT_BITS;
    idx = IW'(FXP_SIZE - p);
    lr_d = bclk_fall ? (int'(bit_nxt) >= SLOT_BITS) : lr_q;
    sd_d = bclk_fall ? ((p >= 1 && p <= FXP_SIZE) & frame_d[idx]) : sd_q;
  end
  // sample path, frame pulses and registered pin drivers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      frame_q <= '0;
      fresh_q <= 1'b0;
      fs_q <= 1'b0;
      ur_q <= 1'b0;
      lr_q <= 1'b0;
      sd_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      frame_q <= frame_d;
      fresh_q <= fresh_d;
      fs_q <= frame_load;
      ur_q <= frame_load & ~fresh_q;
      lr_q <= lr_d;
      sd_q <= sd_d;
    end
  end
  assign o_frame_start = fs_q;
  assign o_underrun = ur_q;
  assign o_lrclk = lr_q;
  assign o_sdata = sd_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: table, scenario and random checks of i2s_tx against a cycle-index model
module tb_i2s_tx;
  logic clk = 0, rst = 1, i_valid = 0;
  logic [15:0] i_sample = 0;
  logic o_frame_start, o_underrun, o_bclk, o_lrclk, o_sdata;
  int t = 0, n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  typedef struct {int e; logic [15:0] v;} cap_t;
  typedef struct {int cyc; logic [4:0] exp;} vec_t;
  cap_t caps[$];
  vec_t tbl[11];

  i2s_tx dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .i_sample(i_sample),
    .o_frame_start(o_frame_start),
    .o_underrun(o_underrun),
    .o_bclk(o_bclk),
    .o_lrclk(o_lrclk),
    .o_sdata(o_sdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) if (!rst) t <= 0; else t <= t + 1;

  function automatic logic [4:0] outs();
    return {o_frame_start, o_underrun, o_bclk, o_lrclk, o_sdata};
  endfunction

  // expected pins after clk edge tt since reset release, from frame arithmetic
  function automatic logic [4:0] model(int tt);
    int n = tt / 512;
    int b = (tt / 8) % 64;
    int p = b % 32;
    logic [15:0] f = 0;
    logic any = 0, fs, ur, sd;
    foreach (caps[i]) begin
      if (caps[i].e < 512 * n) f = caps[i].v;
      if (caps[i].e >= 512 * (n - 1) && caps[i].e < 512 * n) any = 1;
    end
    fs = tt > 0 && tt % 512 == 0;
    ur = fs && !any;
    sd = (p >= 1 && p <= 16) ? f[4'(16 - p)] : 1'b0;
    return {fs, ur, 1'((tt / 4) % 2), b >= 32, sd};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) check($sformatf("pins t=%0d", t), {27'b0, outs()}, {27'b0, model(t)});

  task automatic reset_dut();
    rst = 0;
    caps.delete();
    i_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
  endtask

  task automatic wait_until(input int c);
    int g = 0;
    while (t < c && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("wait_cycle", t, c);
  endtask

  task automatic wait_mod(input int m);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (t % 512 != m && g < 600);
    check("wait_phase", t % 512, m);
  endtask

  task automatic send(input logic [15:0] v);
    i_valid = 1;
    i_sample = v;
    caps.push_back('{t + 1, v});
    @(negedge clk);
    i_valid = 0;
  endtask

  task automatic send_at(input int m, input logic [15:0] v);
    wait_mod(m);
    send(v);
  endtask

  task automatic get_frame(output logic [31:0] l, output logic [31:0] r, output logic ur);
    int g = 0, k = 0;
    logic pb;
    l = 0;
    r = 0;
    while (!o_frame_start && g < 600) begin
      @(negedge clk);
      g++;
    end
    check("frame_start_seen", {31'b0, o_frame_start}, 1);
    ur = o_underrun;
    pb = o_bclk;
    g = 0;
    while (k < 64 && g < 1200) begin
      @(negedge clk);
      g++;
      if (o_bclk && !pb) begin
        if (o_lrclk) r = {r[30:0], o_sdata};
        else l = {l[30:0], o_sdata};
        k++;
      end
      pb = o_bclk;
    end
    check("bits_collected", k, 64);
  endtask

  task automatic expect_frame(input string nm, input logic [15:0] v, input logic eur);
    logic [31:0] l, r;
    logic ur;
    get_frame(l, r, ur);
    check({nm, "_left"}, l, {1'b0, v, 15'b0});
    check({nm, "_right"}, r, {1'b0, v, 15'b0});
    check({nm, "_underrun"}, {31'b0, ur}, {31'b0, eur});
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      wait_until(tbl[i].cyc);
      check($sformatf("table t=%0d", tbl[i].cyc), {27'b0, outs()}, {27'b0, tbl[i].exp});
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{'{3, 5'b00000}, '{4, 5'b00100}, '{7, 5'b00100}, '{8, 5'b00000},
            '{12, 5'b00100}, '{255, 5'b00100}, '{256, 5'b00010}, '{511, 5'b00110},
            '{512, 5'b11000}, '{513, 5'b00000}, '{1024, 5'b11000}};
    #1;
    rst = 0;
    #1;
    chk_en = 1;
    check("reset_pins", {27'b0, outs()}, 0);
    @(negedge clk);
    reset_dut();
    run_table();
    send_at(256, 16'h8001);
    expect_frame("s2_8001", 16'h8001, 0);
    send_at(256, 16'h1234);
    fork
      send_at(256, 16'hFEDC);
      expect_frame("s3_1234", 16'h1234, 0);
    join
    expect_frame("s3_fedc", 16'hFEDC, 0);
    fork
      send_at(511, 16'h0F0F);
      expect_frame("s4_old", 16'hFEDC, 1);
    join
    expect_frame("s4_0f0f", 16'h0F0F, 0);
    fork
      begin
        send_at(100, 16'h1111);
        send_at(300, 16'h2222);
      end
      expect_frame("s5_pre", 16'h0F0F, 1);
    join
    expect_frame("s5_2222", 16'h2222, 0);
    expect_frame("s5_repeat", 16'h2222, 1);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(20, 700)) @(negedge clk);
      if ($urandom_range(0, 3) != 0) send(16'($urandom));
    end
    wait_mod(420);
    check("pre_reset_bclk_lr", {30'b0, o_bclk, o_lrclk}, 2'b11);
    #2;
    rst = 0;
    caps.delete();
    #1;
    check("async_reset_pins", {27'b0, outs()}, 0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1;
    run_table();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
